mac_dot_sequencer: RTL and testbench

- Upstream operand sequencer for mac_unit. Buffers streamed signed 8-bit (A,B) element pairs in a small FIFO and issues them one at a time over the mac_unit valid/done protocol.
- On the element tagged last, captures the 32-bit accumulated sum and a sticky overflow flag. Presents them on a valid/ready result port.
- Resets the MAC between dot products so every result starts from zero.

---
 rtl/mac_dot_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: buffers signed 8-bit (A,B) pairs in a FIFO and feeds them
// one at a time to a mac_unit. On the element tagged last it captures the sum
// and a sticky overflow flag, and offers them on a valid/ready result port.
// The mac_unit is reset between dot products.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   s_valid/s_ready/s_a/s_b/s_last  operand stream input
//   mac_rst/mac_valid/mac_a/mac_b   commands to mac_unit
//   mac_done/mac_y/mac_overflow     responses from mac_unit
//   r_valid/r_ready/r_y/r_ovf/r_count  result port
//   err                          watchdog fired (sticky)
//
// Optional: define MAC_SEQ_TIMEOUT_EN to enable the WAIT_DONE watchdog. Without
// it WAIT_DONE waits indefinitely and err is tied to 0.
module mac_dot_sequencer #(
    parameter int DEPTH          = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_a,
    input  logic [7:0]       s_b,
    input  logic             s_last,
    output logic             mac_rst,
    output logic             mac_valid,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic             mac_done,
    input  logic [31:0]      mac_y,
    input  logic             mac_overflow,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [31:0]      r_y,
    output logic             r_ovf,
    output logic [CNT_W-1:0] r_count,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_CLEAR     = 3'd0,
        S_CLR_WAIT  = 3'd1,
        S_IDLE      = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_SETTLE    = 3'd5,
        S_RESULT    = 3'd6
    } state_t;

    state_t state_q, state_d;

    // FIFO entry layout: {last, a, b}
    logic [16:0]      mem_q [DEPTH];
    logic [16:0]      mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             last_q, last_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      r_y_q, r_y_d;
    logic             r_ovf_q, r_ovf_d;

    logic empty, full, push, pop, tmo_fire;
    logic [16:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = s_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [AW:0]   occ, idx, flush_ptr;
    logic          found;

    assign tmo_fire = (state_q == S_WAIT_DONE) && !mac_done &&
                      (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Read pointer just past the first queued entry tagged last; if no such
    // entry is queued, everything queued belongs to the discarded product.
    always_comb begin
        occ       = wr_ptr_q - rd_ptr_q;
        flush_ptr = wr_ptr_q;
        found     = 1'b0;
        idx       = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + (AW+1)'(i);
            if (!found && ((AW+1)'(i) < occ) && mem_q[idx[AW-1:0]][16]) begin
                found     = 1'b1;
                flush_ptr = idx + (AW+1)'(1);
            end
        end
    end

    assign err = err_q;
`else
    assign tmo_fire = 1'b0;
    assign err      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CLEAR:     state_d = S_CLR_WAIT;
            S_CLR_WAIT:  state_d = S_IDLE;
            S_IDLE:      if (!empty) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (mac_done)      state_d = S_SETTLE;
                else if (tmo_fire) state_d = S_CLEAR;
            end
            S_SETTLE:    state_d = last_q ? S_RESULT : S_IDLE;
            S_RESULT:    if (r_ready) state_d = S_CLEAR;
            default:     state_d = S_CLEAR;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        mac_rst   = (state_q == S_CLEAR);
        mac_valid = (state_q == S_ISSUE);
        r_valid   = (state_q == S_RESULT);
    end

    assign s_ready = !full;
    assign mac_a   = a_q;
    assign mac_b   = b_q;
    assign r_y     = r_y_q;
    assign r_ovf   = r_ovf_q;
    assign r_count = cnt_q;

    // Datapath next-values
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        r_y_d    = r_y_q;
        r_ovf_d  = r_ovf_q;
`ifdef MAC_SEQ_TIMEOUT_EN
        tmo_d    = '0;
        err_d    = err_q;
`endif
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {s_last, s_a, s_b};
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            {last_d, a_d, b_d} = head;
        end
        if (state_q == S_WAIT_DONE && mac_done) begin
            ovf_d = ovf_q | mac_overflow;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == S_SETTLE && last_q) begin
            r_y_d   = mac_y;
            r_ovf_d = ovf_q | mac_overflow;
        end
        if (state_q == S_RESULT && r_ready) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
`ifdef MAC_SEQ_TIMEOUT_EN
        if (state_q == S_WAIT_DONE && !mac_done)
            tmo_d = tmo_q + TW'(1);
        if (tmo_fire) begin
            err_d = 1'b1;
            cnt_d = '0;
            ovf_d = 1'b0;
            // A stalled last element already closed its product, so the
            // queued entries belong to the next one and are kept.
            if (!last_q) rd_ptr_d = flush_ptr;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            r_y_q    <= '0;
            r_ovf_q  <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            r_y_q    <= r_y_d;
            r_ovf_q  <= r_ovf_d;
`ifdef MAC_SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural mac_unit stub, dot-product
// scoreboard and directed vectors with hand-computed literal results.
module tb_mac_dot_sequencer;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid, s_ready, s_last;
    logic [7:0]    s_a, s_b;
    logic          mac_rst, mac_valid, mac_done, mac_overflow;
    logic [7:0]    mac_a, mac_b;
    logic [31:0]   mac_y;
    logic          r_valid, r_ready, r_ovf, err;
    logic [31:0]   r_y;
    logic [CW-1:0] r_count;

    always #5 clk = ~clk;

    mac_dot_sequencer #(.DEPTH(4), .CNT_W(CW), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .s_last(s_last),
        .mac_rst(mac_rst), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
        .mac_done(mac_done), .mac_y(mac_y), .mac_overflow(mac_overflow),
        .r_valid(r_valid), .r_ready(r_ready), .r_y(r_y), .r_ovf(r_ovf),
        .r_count(r_count), .err(err)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- mac_unit stub: done 3 cycles after ISSUE -------------
    logic signed [31:0] start_val = 0;
    logic               no_done   = 1'b0;
    logic               d1, d2, fresh;

    function automatic longint mac_sum(input logic signed [31:0] base,
                                       input logic [7:0] a, input logic [7:0] b);
        return longint'(base) + longint'($signed(a)) * longint'($signed(b));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= 1'b0; d2 <= 1'b0; mac_done <= 1'b0;
            mac_y <= '0; mac_overflow <= 1'b0; fresh <= 1'b1;
        end else begin
            d1       <= mac_valid && !no_done;
            d2       <= d1;
            mac_done <= d2;
            if (mac_rst) begin
                fresh <= 1'b1; mac_y <= '0; mac_overflow <= 1'b0;
            end
            if (d2) begin
                mac_y <= 32'(mac_sum(fresh ? start_val : $signed(mac_y), mac_a, mac_b));
                if (mac_sum(fresh ? start_val : $signed(mac_y), mac_a, mac_b) > 64'sd2147483647 ||
                    mac_sum(fresh ? start_val : $signed(mac_y), mac_a, mac_b) < -64'sd2147483648)
                    mac_overflow <= 1'b1;
                fresh <= 1'b0;
            end
        end
    end

    // ---------------- dot-product model -------------------------------------
    typedef struct { int y; bit ovf; int cnt; } res_t;
    res_t            res_q[$];
    logic [15:0]     op_q[$];
    int              m_n = 0;
    int              m_sum = 0;
    bit              m_ovf = 0;
    int              m_start = 0;
    int              n_acc = 0;
    int              n_res = 0;
    int              rst_cnt = 0;
    int              hist_y[$];
    int              hist_rst[$];
    int              last_cnt;
    bit              last_ovf;

    task automatic model_add(input logic [7:0] a, input logic [7:0] b, input logic l);
        longint t;
        res_t r;
        op_q.push_back({a, b});
        if (m_n == 0) begin m_sum = m_start; m_ovf = 0; end
        t = longint'(m_sum) + longint'($signed(a)) * longint'($signed(b));
        if (t > 64'sd2147483647 || t < -64'sd2147483648) m_ovf = 1;
        m_sum = int'(t[31:0]);
        m_n++;
        if (l) begin
            r.y = m_sum; r.ovf = m_ovf;
            r.cnt = (m_n > (1 << CW) - 1) ? (1 << CW) - 1 : m_n;
            res_q.push_back(r);
            m_n = 0;
        end
    endtask

    task automatic model_reset();
        op_q.delete(); res_q.delete();
        m_n = 0; m_sum = 0; m_ovf = 0;
    endtask

    // ---------------- compare process ---------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            rst_cnt += int'(mac_rst);
            if (mac_valid) begin
                total++;
                if (op_q.size() == 0) begin
                    bad++; $display("FAIL mac_op: unexpected issue a=%0d b=%0d", $signed(mac_a), $signed(mac_b));
                end else begin
                    logic [15:0] e;
                    e = op_q.pop_front();
                    if ({mac_a, mac_b} !== e) begin
                        bad++;
                        $display("FAIL mac_op: got %h want %h", {mac_a, mac_b}, e);
                    end
                end
            end
            if (r_valid && r_ready) begin
                total++;
                if (res_q.size() == 0) begin
                    bad++; $display("FAIL result: unexpected y=%0d", $signed(r_y));
                end else begin
                    res_t e;
                    e = res_q.pop_front();
                    if ($signed(r_y) != e.y || r_ovf != e.ovf || int'(r_count) != e.cnt) begin
                        bad++;
                        $display("FAIL result: got y=%0d ovf=%0d cnt=%0d want y=%0d ovf=%0d cnt=%0d",
                                 $signed(r_y), r_ovf, r_count, e.y, e.ovf, e.cnt);
                    end
                end
                hist_y.push_back($signed(r_y));
                hist_rst.push_back(rst_cnt);
                last_cnt = int'(r_count);
                last_ovf = r_ovf;
                n_res++;
            end
`ifndef MAC_SEQ_TIMEOUT_EN
            total++;
            if (err !== 1'b0) begin
                bad++; $display("FAIL err_tied: got %b want 0", err);
            end
`endif
        end
    end

    // ---------------- helpers -----------------------------------------------
    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic push(input int a, input int b, input logic l);
        int k = 0;
        s_valid = 1'b1; s_a = 8'(a); s_b = 8'(b); s_last = l;
        @(negedge clk);
        while (!s_ready && k < 200) begin @(negedge clk); k++; end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL push_timeout: s_ready=%b want 1", s_ready);
            @(posedge clk); #1;
            s_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            model_add(8'(a), 8'(b), l);
            s_valid = 1'b0;
            n_acc++;
        end
    endtask

    task automatic wait_res(input int n);
        int k = 0;
        while (n_res < n && k < 500) begin @(negedge clk); k++; end
        if (n_res < n) begin
            total++; bad++;
            $display("FAIL wait_res: results=%0d want %0d", n_res, n);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed stimulus -------------------------------------
    initial begin
        int base;
        int k;
        reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0;
        r_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_mac_rst", int'(mac_rst), 1);
        chk("rst_r_valid", int'(r_valid), 0);
        chk("rst_mac_valid", int'(mac_valid), 0);
        chk("rst_r_count", int'(r_count), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #1;

        // 3*4 - 2*5 + 10*10 = 102
        push(3, 4, 0); push(-2, 5, 0); push(10, 10, 1);
        wait_res(1);
        chk("dot3_y", hist_y[0], 102);
        chk("dot3_cnt", last_cnt, 3);
        chk("dot3_ovf", int'(last_ovf), 0);

        // back-to-back single-element products
        push(2, 2, 1); push(-1, 7, 1);
        wait_res(3);
        chk("b2b_y0", hist_y[1], 4);
        chk("b2b_y1", hist_y[2], -7);
        chk("b2b_rst", hist_rst[2] - hist_rst[1], 1);

        // counter saturates at 3 with CNT_W=2; sum keeps accumulating
        for (int i = 0; i < 5; i++) push(1, 1, i == 4);
        wait_res(4);
        chk("sat_y", hist_y[3], 5);
        chk("sat_cnt", last_cnt, 3);

        // FIFO fills while the sequencer is parked in RESULT
        r_ready = 1'b0;
        push(2, 3, 1);
        k = 0;
        while (!r_valid && k < 100) begin @(negedge clk); k++; end
        chk("park_r_valid", int'(r_valid), 1);
        @(posedge clk); #1;
        base = n_acc;
        fork
            begin
                push(1, 2, 0); push(3, 4, 1); push(5, 6, 0);
                push(7, 8, 0); push(9, 10, 1);
            end
            begin
                k = 0;
                while (n_acc < base + 4 && k < 100) begin @(negedge clk); k++; end
                repeat (3) @(negedge clk);
                chk("full_s_ready", int'(s_ready), 0);
                chk("full_acc", n_acc - base, 4);
                chk("full_r_valid", int'(r_valid), 1);
                @(posedge clk); #1;
                r_ready = 1'b1;
            end
        join
        wait_res(7);
        chk("full_y0", hist_y[4], 6);
        chk("full_y1", hist_y[5], 14);
        chk("full_y2", hist_y[6], 176);

        // accumulator crosses 2^31-1 on the second 127*127
        start_val = 2147463647; m_start = 2147463647;
        push(127, 127, 0); push(127, 127, 0); push(127, 127, 1);
        wait_res(8);
        chk("ovf_y", hist_y[7], -2147455262);
        chk("ovf_flag", int'(last_ovf), 1);
        start_val = 0; m_start = 0;
        push(1, 1, 1);
        wait_res(9);
        chk("ovf_next_flag", int'(last_ovf), 0);
        chk("ovf_next_y", hist_y[8], 1);

        // reset during WAIT_DONE with two entries queued
        push(1, 1, 0); push(2, 2, 0); push(3, 3, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_ready", int'(s_ready), 1);
        chk("mid_rst_r_valid", int'(r_valid), 0);
        chk("mid_rst_mac_rst", int'(mac_rst), 1);
        @(posedge clk); #1;
        push(4, 5, 1);
        wait_res(10);
        chk("post_rst_y", hist_y[9], 20);
        chk("post_rst_cnt", last_cnt, 1);

`ifdef MAC_SEQ_TIMEOUT_EN
        no_done = 1'b1;
        push(1, 1, 1);
        k = 0;
        while (!mac_valid && k < 50) begin @(negedge clk); k++; end
        chk("tmo_issue", int'(mac_valid), 1);
        k = 0;
        while (!err && k < 100) begin @(negedge clk); k++; end
        chk("tmo_cycles", k, 16);
        chk("tmo_err", int'(err), 1);
        chk("tmo_clear", int'(mac_rst), 1);
        chk("tmo_no_result", int'(r_valid), 0);
        res_q.delete();
        no_done = 1'b0;
        @(posedge clk); #1;
        push(2, 3, 1);
        wait_res(11);
        chk("tmo_after_y", hist_y[10], 6);
        chk("tmo_results", n_res, 11);
`endif

        repeat (5) @(posedge clk);
        chk("left_ops", op_q.size(), 0);
        chk("left_results", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
